// File: rtl/osc_pkg.sv
// osc_pkg: shared trigger encodings, capture states and default widths
package osc_pkg;
  localparam int DEF_DATA_W = 8;
  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READY} cap_state_t;
endpackage

// File: rtl/adc_frame_capture_if.sv
// adc_frame_capture_if: byte read port between the frame capture and the GPIO sender
interface adc_frame_capture_if #(parameter int DATA_W = osc_pkg::DEF_DATA_W);
  logic              frame_ready;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  modport master (output frame_ready, rd_data, rd_valid, rd_last, input rd_en);
  modport slave  (input frame_ready, rd_data, rd_valid, rd_last, output rd_en);
endinterface

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port RAM, synchronous write, registered read with enable
module frame_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd_q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // Output register holds between reads so the sender sees a stable byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_q <= '0;
    else if (re) rd_q <= mem[ra];
endmodule

// File: rtl/adc_frame_capture.sv
// adc_frame_capture: triggered, decimated ADC frame capture drained byte-by-byte
module adc_frame_capture
  import osc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [7:0]        decim,
  output logic              busy,
  adc_frame_capture_if.master rd
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic              we, re, rise, fall, trig;
  assign rise = have_prev_q && prev_q <  trig_level && adc_data >= trig_level;
  assign fall = have_prev_q && prev_q >= trig_level && adc_data <  trig_level;
  assign trig = (trig_mode == TRIG_RISE) ? rise : (trig_mode == TRIG_FALL) ? fall : 1'b1;
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dcnt_d      = dcnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    case (state_q)
      IDLE: if (arm) begin
        state_d     = ARMED;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        dcnt_d      = '0;
        have_prev_d = 1'b0;
      end
      ARMED: if (adc_valid) begin
        prev_d      = adc_data;
        have_prev_d = 1'b1;
        if (trig) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          dcnt_d   = decim;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: if (adc_valid) begin
        if (dcnt_q == '0) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          dcnt_d   = decim;
          state_d  = (wr_ptr_q == LAST) ? READY : CAPTURE;
        end else
          dcnt_d = dcnt_q - 8'd1;
      end
      READY: if (rd.rd_en) begin
        re         = 1'b1;
        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        rd_valid_d = 1'b1;
        rd_last_d  = (rd_ptr_q == LAST);
        state_d    = (rd_ptr_q == LAST) ? IDLE : READY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dcnt_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dcnt_q      <= dcnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  frame_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wr_ptr_q),
    .wd    (adc_data),
    .re    (re),
    .ra    (rd_ptr_q),
    .rd_q  (rd.rd_data)
  );
  assign busy           = (state_q != IDLE);
  assign rd.frame_ready = (state_q == READY);
  assign rd.rd_valid    = rd_valid_q;
  assign rd.rd_last     = rd_last_q;
endmodule

// File: tb/tb_adc_frame_capture.sv
// tb_adc_frame_capture: directed checks of trigger, decimation, hold and drain behaviour
module tb_adc_frame_capture;
  localparam int FL = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       adc_valid = 1'b0;
  logic [7:0] adc_data = '0;
  logic [7:0] trig_level = '0;
  logic [7:0] decim = '0;
  logic [1:0] trig_mode = '0;
  logic       busy;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q [FL];
  adc_frame_capture_if #(.DATA_W(8)) rd();
  adc_frame_capture #(.DATA_W(8), .ADDR_W(8), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .decim      (decim),
    .busy       (busy),
    .rd         (rd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask
  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic drain(input int gap_at, input bit arm_last);
    for (int i = 0; i < FL; i++) begin
      if (i == gap_at) begin
        rd.rd_en = 1'b0;
        tick();
        tick();
        chk("gap_valid", {7'd0, rd.rd_valid}, 8'd0);
        chk("gap_hold", rd.rd_data, exp_q[i-1]);
        chk("gap_ready", {7'd0, rd.frame_ready}, 8'd1);
      end
      rd.rd_en = 1'b1;
      arm = arm_last && (i == FL - 1);
      tick();
      chk($sformatf("data%0d", i), rd.rd_data, exp_q[i]);
      chk($sformatf("valid%0d", i), {7'd0, rd.rd_valid}, 8'd1);
      chk($sformatf("last%0d", i), {7'd0, rd.rd_last}, {7'd0, i == FL - 1});
      chk($sformatf("ready%0d", i), {7'd0, rd.frame_ready}, {7'd0, i != FL - 1});
    end
    rd.rd_en = 1'b0;
    arm = 1'b0;
    chk("end_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("post_valid", {7'd0, rd.rd_valid}, 8'd0);
    chk("post_last", {7'd0, rd.rd_last}, 8'd0);
    chk("post_hold", rd.rd_data, exp_q[FL-1]);
    chk("post_busy", {7'd0, busy}, 8'd0);
  endtask
  initial begin
    rd.rd_en = 1'b0;
    tick();
    tick();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready", {7'd0, rd.frame_ready}, 8'd0);
    chk("rst_valid", {7'd0, rd.rd_valid}, 8'd0);
    chk("rst_last", {7'd0, rd.rd_last}, 8'd0);
    chk("rst_data", rd.rd_data, 8'd0);
    rst_n = 1'b1;
    tick();
    // immediate trigger, ramp, continuous drain
    trig_mode = 2'd0;
    decim = 8'd0;
    pulse_arm();
    chk("imm_busy", {7'd0, busy}, 8'd1);
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) chk("imm_early", {7'd0, rd.frame_ready}, 8'd0);
      send(8'(i));
      exp_q[i] = 8'(i);
    end
    chk("imm_ready", {7'd0, rd.frame_ready}, 8'd1);
    drain(-1, 1'b0);
    // rising edge; first sample above level must not trigger
    trig_mode = 2'd1;
    trig_level = 8'h80;
    pulse_arm();
    send(8'h90);
    send(8'h70);
    send(8'h7F);
    chk("rise_wait", {7'd0, rd.frame_ready}, 8'd0);
    chk("rise_busy", {7'd0, busy}, 8'd1);
    exp_q = '{8'h80, 8'h90, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < FL; i++) send(exp_q[i]);
    chk("rise_ready", {7'd0, rd.frame_ready}, 8'd1);
    drain(3, 1'b0);
    // falling edge with decimation, idle cycles between samples
    trig_mode = 2'd2;
    trig_level = 8'h40;
    decim = 8'd2;
    pulse_arm();
    send(8'h50);
    send(8'h30);
    for (int k = 1; k <= 3 * (FL - 1); k++) begin
      if (k == 3 * (FL - 1)) chk("fall_early", {7'd0, rd.frame_ready}, 8'd0);
      send(8'(8'h30 + k));
      tick();
    end
    for (int j = 0; j < FL; j++) exp_q[j] = 8'(8'h30 + 3 * j);
    chk("fall_ready", {7'd0, rd.frame_ready}, 8'd1);
    // frame must survive samples and arm while READY
    adc_data = 8'hFF;
    adc_valid = 1'b1;
    pulse_arm();
    tick();
    tick();
    adc_valid = 1'b0;
    chk("hold_busy", {7'd0, busy}, 8'd1);
    chk("hold_ready", {7'd0, rd.frame_ready}, 8'd1);
    drain(5, 1'b0);
    // asynchronous reset mid-capture
    trig_mode = 2'd0;
    decim = 8'd0;
    pulse_arm();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_ready", {7'd0, rd.frame_ready}, 8'd0);
    chk("mid_valid", {7'd0, rd.rd_valid}, 8'd0);
    chk("mid_last", {7'd0, rd.rd_last}, 8'd0);
    chk("mid_data", rd.rd_data, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd.rd_en = 1'b1;
    tick();
    rd.rd_en = 1'b0;
    chk("idle_rd_valid", {7'd0, rd.rd_valid}, 8'd0);
    chk("idle_rd_data", rd.rd_data, 8'd0);
    pulse_arm();
    for (int i = 0; i < FL; i++) begin
      exp_q[i] = 8'(8'hC0 + i);
      send(exp_q[i]);
    end
    chk("rearm_ready", {7'd0, rd.frame_ready}, 8'd1);
    drain(-1, 1'b1);
    tick();
    chk("arm_last_ignored", {7'd0, busy}, 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
